uart_tx_word_queue: RTL and testbench

Parametrised successor to the single-word UART send buffer. It queues CPU output words in a FIFO of configurable depth and serialises each word into bytes for the UART sender, using per-word byte counts and a selectable byte order. It sits between the execution stage (a RegtoUART write pushes a word) and the `sender` module's `sender_data`/`sender_enable`/`sender_ready` handshake. It also gives the pipeline backpressure and a sticky overflow flag.

---
 rtl/uart_tx_word_queue.sv | 203 ++++++++++++++++++++
 tb/tb_uart_tx_word_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_word_queue
// Brief    : Word FIFO feeding a byte serializer for the UART sender, with
//            per-word byte counts, selectable byte order and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_word_queue #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH_LOG2 = 3,
    parameter int BIG_ENDIAN = 1
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        push_valid,
    input  logic [8*WORD_BYTES-1:0]     push_data,
    input  logic [$clog2(WORD_BYTES):0] push_nbytes,
    output logic                        push_ready,
    input  logic                        sender_ready,
    output logic [7:0]                  byte_data,
    output logic                        byte_valid,
    output logic [DEPTH_LOG2:0]         level,
    output logic                        busy,
    output logic                        overflow
);

    localparam int c_W     = 8 * WORD_BYTES;
    localparam int c_NB_W  = $clog2(WORD_BYTES) + 1;
    localparam int c_ENTRIES = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH = (DEPTH_LOG2+1)'(c_ENTRIES);
    localparam logic [c_NB_W-1:0]   c_WB    = c_NB_W'(WORD_BYTES);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ARM    = 2'd1;
    localparam logic [1:0] c_WAITLO = 2'd2;
    localparam logic [1:0] c_WAITHI = 2'd3;

    logic [c_W-1:0]        r_mem_data [0:c_ENTRIES-1];
    logic [c_NB_W-1:0]     r_mem_nb   [0:c_ENTRIES-1];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    logic [1:0]            r_state;
    logic [c_W-1:0]        r_shift;
    logic [c_NB_W-1:0]     r_rem;
    logic [7:0]            r_byte_data;
    logic                  r_byte_valid;
    logic                  r_abort;

    logic [1:0]            w_state_nxt;
    logic [c_W-1:0]        w_shift_nxt;
    logic [c_NB_W-1:0]     w_rem_nxt;
    logic [7:0]            w_byte_data_nxt;
    logic                  w_byte_valid_nxt;
    logic                  w_abort_nxt;
    logic                  w_pop;

    logic                  w_can_push;
    logic                  w_push;
    logic [c_W-1:0]        w_head_data;
    logic [c_NB_W-1:0]     w_head_nb_raw;
    logic [c_NB_W-1:0]     w_head_nb;
    logic [c_W-1:0]        w_load_word;
    logic [7:0]            w_cur_byte;
    logic [c_W-1:0]        w_shifted;

    // Full is judged on the registered count only; a same-cycle pop never frees a slot.
    assign w_can_push = (r_count != c_DEPTH);
    assign push_ready = !reset && w_can_push;
    assign w_push     = push_valid && push_ready && !flush;

    assign w_head_data   = r_mem_data[r_rptr];
    assign w_head_nb_raw = r_mem_nb[r_rptr];
    assign w_head_nb     = (w_head_nb_raw == '0) ? c_WB : w_head_nb_raw;

    if (BIG_ENDIAN != 0) begin : g_big_endian
        logic [c_NB_W+2:0] w_lshamt;
        // Left-align so the most-significant valid byte sits in the top lane.
        assign w_lshamt    = {c_WB - w_head_nb, 3'b000};
        assign w_load_word = w_head_data << w_lshamt;
        assign w_cur_byte  = r_shift[c_W-1 -: 8];
        assign w_shifted   = r_shift << 8;
    end else begin : g_little_endian
        assign w_load_word = w_head_data;
        assign w_cur_byte  = r_shift[7:0];
        assign w_shifted   = r_shift >> 8;
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= push_data;
            r_mem_nb[r_wptr]   <= push_nbytes;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + DEPTH_LOG2'(1);
            end
            if (push_valid && !w_can_push) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_rem_nxt        = r_rem;
        w_byte_data_nxt  = r_byte_data;
        w_byte_valid_nxt = 1'b0;
        w_abort_nxt      = r_abort;
        w_pop            = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_abort_nxt = 1'b0;
                if (!flush && (r_count != '0)) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_load_word;
                    w_rem_nxt   = w_head_nb;
                    w_state_nxt = c_ARM;
                end
            end
            c_ARM: begin
                if (flush) begin
                    w_state_nxt = c_IDLE;
                end else if (sender_ready) begin
                    w_byte_data_nxt  = w_cur_byte;
                    w_byte_valid_nxt = 1'b1;
                    w_state_nxt      = c_WAITLO;
                end
            end
            c_WAITLO: begin
                // A strobed byte always finishes its handshake; flush only
                // marks the rest of the word for discard.
                if (flush) begin
                    w_abort_nxt = 1'b1;
                end
                if (!sender_ready) begin
                    w_state_nxt = c_WAITHI;
                end
            end
            c_WAITHI: begin
                if (flush) begin
                    w_abort_nxt = 1'b1;
                end
                if (sender_ready) begin
                    w_rem_nxt   = r_rem - c_NB_W'(1);
                    w_shift_nxt = w_shifted;
                    if ((r_rem == c_NB_W'(1)) || r_abort || flush) begin
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_state_nxt = c_ARM;
                    end
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_shift      <= '0;
            r_rem        <= '0;
            r_byte_data  <= 8'h00;
            r_byte_valid <= 1'b0;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_rem        <= w_rem_nxt;
            r_byte_data  <= w_byte_data_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_abort      <= w_abort_nxt;
        end
    end

    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign level      = r_count;
    assign busy       = (r_state != c_IDLE) || (r_count != '0);
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_word_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_word_queue
// Brief    : Directed bench; big- and little-endian instances share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_word_queue;

    logic        CLK;
    logic        reset;
    logic        flush;
    logic        push_valid;
    logic [31:0] push_data;
    logic [2:0]  push_nbytes;
    logic        sender_ready;

    logic        push_ready_be, byte_valid_be, busy_be, overflow_be;
    logic [7:0]  byte_data_be;
    logic [3:0]  level_be;
    logic        push_ready_le, byte_valid_le, busy_le, overflow_le;
    logic [7:0]  byte_data_le;
    logic [3:0]  level_le;

    int checks   = 0;
    int failures = 0;

    logic [7:0] cap_be[$];
    logic [7:0] cap_le[$];
    bit         sender_auto = 1'b1;
    int         hold = 0;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  nb;
        int          n;
        logic [31:0] exp_be;
        logic [31:0] exp_le;
    } vec_t;

    vec_t vecs [5];

    uart_tx_word_queue #(.WORD_BYTES(4), .DEPTH_LOG2(3), .BIG_ENDIAN(1)) u_dut_be (
        .CLK(CLK), .reset(reset), .flush(flush),
        .push_valid(push_valid), .push_data(push_data), .push_nbytes(push_nbytes),
        .push_ready(push_ready_be), .sender_ready(sender_ready),
        .byte_data(byte_data_be), .byte_valid(byte_valid_be),
        .level(level_be), .busy(busy_be), .overflow(overflow_be)
    );

    uart_tx_word_queue #(.WORD_BYTES(4), .DEPTH_LOG2(3), .BIG_ENDIAN(0)) u_dut_le (
        .CLK(CLK), .reset(reset), .flush(flush),
        .push_valid(push_valid), .push_data(push_data), .push_nbytes(push_nbytes),
        .push_ready(push_ready_le), .sender_ready(sender_ready),
        .byte_data(byte_data_le), .byte_valid(byte_valid_le),
        .level(level_le), .busy(busy_le), .overflow(overflow_le)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Strobe collector.
    initial begin
        forever begin
            @(negedge CLK);
            if (byte_valid_be === 1'b1) cap_be.push_back(byte_data_be);
            if (byte_valid_le === 1'b1) cap_le.push_back(byte_data_le);
        end
    end

    // Sender model: ready drops for 10 cycles after each strobe.
    initial begin
        sender_ready = 1'b1;
        forever begin
            @(negedge CLK);
            if (sender_auto) begin
                if (hold > 0) begin
                    hold = hold - 1;
                    if (hold == 0) sender_ready = 1'b1;
                end else if (byte_valid_be === 1'b1) begin
                    sender_ready = 1'b0;
                    hold = 10;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] nb);
        push_valid  = 1'b1;
        push_data   = d;
        push_nbytes = nb;
        @(negedge CLK);
        push_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (!busy_be) begin
                done = 1'b1;
                break;
            end
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    function automatic logic [31:0] ovf_word(input int k);
        return {8'(16*k), 8'(16*k+1), 8'(16*k+2), 8'(16*k+3)};
    endfunction

    initial begin
        vec_t        v;
        logic [31:0] w;
        logic [7:0]  got;
        bit          saw;

        vecs[0] = '{32'h11223344, 3'd0, 4, 32'h11223344, 32'h44332211};
        vecs[1] = '{32'hAABBCCDD, 3'd2, 2, 32'hCCDD0000, 32'hDDCC0000};
        vecs[2] = '{32'h00000041, 3'd1, 1, 32'h41000000, 32'h41000000};
        vecs[3] = '{32'hDEADBEEF, 3'd3, 3, 32'hADBEEF00, 32'hEFBEAD00};
        vecs[4] = '{32'h01020304, 3'd4, 4, 32'h01020304, 32'h04030201};

        reset = 1'b1; flush = 1'b0; push_valid = 1'b0;
        push_data = 32'h0; push_nbytes = 3'd0;
        repeat (3) @(negedge CLK);
        check("rst_byte_valid", {31'd0, byte_valid_be}, 32'd0);
        check("rst_byte_data",  {24'd0, byte_data_be}, 32'd0);
        check("rst_level",      {28'd0, level_be}, 32'd0);
        check("rst_push_ready", {31'd0, push_ready_be}, 32'd0);
        check("rst_busy",       {31'd0, busy_be}, 32'd0);
        check("rst_overflow",   {31'd0, overflow_be}, 32'd0);
        reset = 1'b0;
        @(negedge CLK);
        check("post_rst_push_ready", {31'd0, push_ready_be}, 32'd1);

        // Table-driven single words: latency, byte order, partial words.
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            cap_be.delete();
            cap_le.delete();
            push(v.data, v.nb);
            check($sformatf("v%0d_level1", i), {28'd0, level_be}, 32'd1);
            @(negedge CLK);
            check($sformatf("v%0d_lat_n1", i), {31'd0, byte_valid_be}, 32'd0);
            @(negedge CLK);
            check($sformatf("v%0d_lat_n2", i), {31'd0, byte_valid_be}, 32'd1);
            wait_idle($sformatf("v%0d_idle", i), 200);
            check($sformatf("v%0d_level0", i), {28'd0, level_be}, 32'd0);
            check($sformatf("v%0d_nbytes_be", i), cap_be.size(), v.n);
            check($sformatf("v%0d_nbytes_le", i), cap_le.size(), v.n);
            for (int b = 0; b < v.n; b++) begin
                got = (b < cap_be.size()) ? cap_be[b] : 8'h00;
                check($sformatf("v%0d_be_byte%0d", i, b), {24'd0, got}, {24'd0, v.exp_be[31-8*b -: 8]});
                got = (b < cap_le.size()) ? cap_le[b] : 8'h00;
                check($sformatf("v%0d_le_byte%0d", i, b), {24'd0, got}, {24'd0, v.exp_le[31-8*b -: 8]});
            end
        end

        // Full / overflow with the sender stalled.
        cap_be.delete();
        cap_le.delete();
        sender_auto  = 1'b0;
        sender_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            push_valid  = 1'b1;
            push_data   = ovf_word(k);
            push_nbytes = 3'd0;
            @(negedge CLK);
        end
        push_valid = 1'b0;
        check("full_level",      {28'd0, level_be}, 32'd8);
        check("full_push_ready", {31'd0, push_ready_be}, 32'd0);
        check("full_overflow",   {31'd0, overflow_be}, 32'd1);
        check("full_no_strobe",  cap_be.size(), 0);
        sender_ready = 1'b1;
        sender_auto  = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (push_ready_be) begin
                saw = 1'b1;
                break;
            end
        end
        check("push_ready_rise", {31'd0, saw}, 32'd1);
        wait_idle("ovf_idle", 2000);
        check("ovf_nbytes_be", cap_be.size(), 36);
        check("ovf_nbytes_le", cap_le.size(), 36);
        for (int k = 1; k <= 9; k++) begin
            w = ovf_word(k);
            for (int b = 0; b < 4; b++) begin
                got = ((4*(k-1)+b) < cap_be.size()) ? cap_be[4*(k-1)+b] : 8'h00;
                check($sformatf("ovf_be_w%0d_b%0d", k, b), {24'd0, got}, {24'd0, w[31-8*b -: 8]});
                got = ((4*(k-1)+b) < cap_le.size()) ? cap_le[4*(k-1)+b] : 8'h00;
                check($sformatf("ovf_le_w%0d_b%0d", k, b), {24'd0, got}, {24'd0, w[8*b +: 8]});
            end
        end
        check("ovf_sticky", {31'd0, overflow_be}, 32'd1);

        // Flush one cycle after the second strobe with three words queued.
        cap_be.delete();
        cap_le.delete();
        for (int k = 0; k < 4; k++) begin
            push_valid  = 1'b1;
            push_data   = (k == 0) ? 32'h11223344 : ovf_word(k + 11);
            push_nbytes = 3'd0;
            @(negedge CLK);
        end
        push_valid = 1'b0;
        check("flush_pre_level", {28'd0, level_be}, 32'd3);
        saw = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            #1;
            if (cap_be.size() >= 2) begin
                saw = 1'b1;
                break;
            end
        end
        check("flush_second_strobe", {31'd0, saw}, 32'd1);
        @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        check("flush_level",    {28'd0, level_be}, 32'd0);
        check("flush_overflow", {31'd0, overflow_be}, 32'd0);
        wait_idle("flush_idle", 100);
        repeat (30) @(negedge CLK);
        check("flush_busy",      {31'd0, busy_be}, 32'd0);
        check("flush_nbytes_be", cap_be.size(), 2);
        check("flush_nbytes_le", cap_le.size(), 2);
        got = (cap_be.size() > 1) ? cap_be[1] : 8'h00;
        check("flush_be_byte1", {24'd0, got}, 32'h22);
        got = (cap_le.size() > 1) ? cap_le[1] : 8'h00;
        check("flush_le_byte1", {24'd0, got}, 32'h33);

        // Reset while the first byte is in WAITLO.
        cap_be.delete();
        cap_le.delete();
        push(32'h11223344, 3'd0);
        push(32'hCAFEF00D, 3'd0);
        saw = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (byte_valid_be) begin
                saw = 1'b1;
                break;
            end
        end
        check("rstmid_strobe", {31'd0, saw}, 32'd1);
        reset = 1'b1;
        @(negedge CLK);
        check("rstmid_byte_valid", {31'd0, byte_valid_be}, 32'd0);
        check("rstmid_byte_data",  {24'd0, byte_data_be}, 32'd0);
        check("rstmid_level",      {28'd0, level_be}, 32'd0);
        check("rstmid_push_ready", {31'd0, push_ready_be}, 32'd0);
        check("rstmid_busy",       {31'd0, busy_be}, 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        cap_be.delete();
        cap_le.delete();
        push(32'h55667788, 3'd0);
        wait_idle("rstmid_idle", 200);
        check("rstmid_nbytes_be", cap_be.size(), 4);
        got = (cap_be.size() > 0) ? cap_be[0] : 8'h00;
        check("rstmid_be_first", {24'd0, got}, 32'h55);
        got = (cap_le.size() > 0) ? cap_le[0] : 8'h00;
        check("rstmid_le_first", {24'd0, got}, 32'h88);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
